// File: rtl/bitstream_prefetch_ram_pkg.sv
// Shared types and default widths for the bitstream prefetch RAM.
package bitstream_prefetch_ram_pkg;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_ADDR_W     = 17;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } stream_state_t;

endpackage

// File: rtl/bs_sync_fifo.sv
// Small synchronous FIFO with synchronous flush; reused by later bitstream stages.
module bs_sync_fifo #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_flush,
    input  logic                          i_push,
    input  logic [DATA_W-1:0]             i_push_data,
    input  logic                          i_pop,
    output logic [DATA_W-1:0]             o_head,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_full,
    output logic                          o_empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_pop;
    logic              w_do_push;

    // A push into a full FIFO is accepted only when a pop frees the slot the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(FIFO_DEPTH)) || w_do_pop);

    // Entry storage; no reset needed since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/bitstream_prefetch_ram.sv
// Bitstream store: load port, circular streaming engine into a prefetch FIFO,
// and a legacy random-read port usable while the engine is idle.
module bitstream_prefetch_ram
    import bitstream_prefetch_ram_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              eos,
    output logic              busy,
    input  logic              rnd_ren_n,
    input  logic [ADDR_W-1:0] rnd_addr,
    output logic [DATA_W-1:0] rnd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned LEN_W = ADDR_W + 1;

    stream_state_t      r_state;
    stream_state_t      w_state_nxt;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_ptr;
    logic [ADDR_W-1:0]  r_end_addr;
    logic [LEN_W-1:0]   r_left;
    logic               r_inflight;
    logic [DATA_W-1:0]  r_strm_q;
    logic [DATA_W-1:0]  r_rnd_data;
    logic               r_eos;
    logic               r_busy;

    logic [DATA_W-1:0]  w_fifo_head;
    logic [CNT_W-1:0]   w_fifo_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_fifo_push;
    logic               w_fifo_pop;
    logic               w_head_valid;
    logic               w_pop;
    logic               w_last_pop;
    logic               w_credit;
    logic               w_issue;
    logic               w_engine_idle;
    logic               w_rnd_rd;
    logic [ADDR_W-1:0]  w_span;

    // Read credit counts both buffered words and the word currently in flight.
    assign w_credit      = !w_fifo_full &&
                           ((SUM_W'(w_fifo_count) + SUM_W'(r_inflight)) < SUM_W'(FIFO_DEPTH));
    assign w_issue       = (r_state == ST_FETCH) && !start && w_credit;
    assign w_engine_idle = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_rnd_rd      = w_engine_idle && !rnd_ren_n;

    // The in-flight word bypasses an empty FIFO; otherwise it queues behind the head.
    assign w_head_valid  = !w_fifo_empty || r_inflight;
    assign w_pop         = w_head_valid && rd_ready;
    assign w_fifo_pop    = !w_fifo_empty && rd_ready;
    assign w_fifo_push   = r_inflight && !(w_fifo_empty && rd_ready);
    assign w_last_pop    = (r_state == ST_DRAIN) && w_pop && (r_left == LEN_W'(1));
    assign w_span        = end_addr - start_addr;

    bs_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (start),
        .i_push      (w_fifo_push),
        .i_push_data (r_strm_q),
        .i_pop       (w_fifo_pop),
        .o_head      (w_fifo_head),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Shared synchronous read port: streaming owns it while busy, random port otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_strm_q   <= '0;
            r_rnd_data <= '0;
        end else begin
            if (w_issue) begin
                r_strm_q <= r_mem[r_ptr];
            end
            if (w_rnd_rd) begin
                r_rnd_data <= r_mem[rnd_addr];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; start from any state restarts the stream.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (start) begin
                    w_state_nxt = ST_FETCH;
                end else if (w_issue && (r_ptr == r_end_addr)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (start) begin
                    w_state_nxt = ST_FETCH;
                end else if (w_last_pop) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  if (start) w_state_nxt = ST_FETCH;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Stream pointers, remaining-word count, in-flight tag and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr      <= '0;
            r_end_addr <= '0;
            r_left     <= '0;
            r_inflight <= 1'b0;
            r_eos      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_DRAIN);
            if (start) begin
                r_ptr      <= start_addr;
                r_end_addr <= end_addr;
                r_left     <= LEN_W'(w_span) + LEN_W'(1);
                r_inflight <= 1'b0;
                r_eos      <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                end
                if (w_pop) begin
                    r_left <= r_left - LEN_W'(1);
                end
                if (w_last_pop) begin
                    r_eos <= 1'b1;
                end
            end
        end
    end

    assign rd_valid = w_head_valid;
    assign rd_data  = !w_fifo_empty ? w_fifo_head : (r_inflight ? r_strm_q : '0);
    assign eos      = r_eos;
    assign busy     = r_busy;
    assign rnd_data = r_rnd_data;

endmodule
